// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: executes stack-machine opcodes against an 8-bit LIFO.
// Optional occupancy/underflow/overflow checker: define STACK_DEPTH_CHECK_EN.
module stack_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] op_imm,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              stk_push,
    output logic              stk_pop,
    output logic              stk_tos,
    output logic [DATA_W-1:0] stk_din,
    input  logic [DATA_W-1:0] stk_dout,
    output logic              err
);

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_DUP  = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WR,
        RES
    } state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic              ready_q;
    logic              busy_q;
    logic              push_q;
    logic              pop_q;
    logic              tos_q;
    logic [DATA_W-1:0] din_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;

    logic              accept;
    logic              reject;
    logic [DATA_W-1:0] bin_res;

    // The checker needs room for two operands to be meaningful.
    if (DEPTH < 2 || DATA_W < 1) begin : g_bad_cfg
        $error("stack_op_sequencer: DEPTH must be >= 2, DATA_W >= 1");
    end

    // ready_q is high only in IDLE, so this is the handshake edge.
    assign accept = op_valid && ready_q;

    // Binary result: B arrives on stk_dout during RD_B, A is held.
    always_comb begin
        bin_res = stk_dout & a_q;
        unique case (op_q)
            OP_ADD:  bin_res = stk_dout + a_q;
            OP_SUB:  bin_res = stk_dout - a_q;
            default: bin_res = stk_dout & a_q;
        endcase
    end

`ifdef STACK_DEPTH_CHECK_EN
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_TWO  = OCC_W'(2);

    logic [OCC_W-1:0] occ_q;
    logic             err_q;

    // Reject ops that would under- or overflow the stack.
    always_comb begin
        reject = 1'b0;
        unique case (op_code)
            OP_PUSH: reject = (occ_q == OCC_FULL);
            OP_POP:  reject = (occ_q == '0);
            OP_NOT:  reject = (occ_q == '0);
            OP_DUP:  reject = (occ_q == '0) || (occ_q == OCC_FULL);
            OP_ADD:  reject = (occ_q < OCC_TWO);
            OP_SUB:  reject = (occ_q < OCC_TWO);
            OP_AND:  reject = (occ_q < OCC_TWO);
            default: reject = 1'b0;
        endcase
    end

    // Occupancy follows the push/pop strobes as the stack sees them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else if (push_q) begin
            occ_q <= occ_q + 1'b1;
        end else if (pop_q) begin
            occ_q <= occ_q - 1'b1;
        end
    end

    // Sticky error on any rejected op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && reject) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    // Main FSM; all outputs are registered for the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            a_q         <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            tos_q       <= 1'b0;
            din_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            res_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept && !reject) begin
                        op_q <= op_code;
                        unique case (op_code)
                            OP_NOP: begin
                                state_q <= IDLE;
                            end
                            OP_PUSH: begin
                                state_q <= WR;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b1;
                                push_q  <= 1'b1;
                                din_q   <= op_imm;
                            end
                            default: begin
                                state_q <= RD_A;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b1;
                                tos_q   <= 1'b1;
                                pop_q   <= (op_code != OP_DUP);
                            end
                        endcase
                    end
                end
                RD_A: begin
                    a_q   <= stk_dout;
                    tos_q <= 1'b0;
                    pop_q <= 1'b0;
                    unique case (op_q)
                        OP_POP: begin
                            state_q     <= RES;
                            res_valid_q <= 1'b1;
                            res_data_q  <= stk_dout;
                        end
                        OP_NOT: begin
                            state_q <= WR;
                            push_q  <= 1'b1;
                            din_q   <= ~stk_dout;
                        end
                        OP_DUP: begin
                            state_q <= WR;
                            push_q  <= 1'b1;
                            din_q   <= stk_dout;
                        end
                        default: begin
                            state_q <= RD_B;
                            tos_q   <= 1'b1;
                            pop_q   <= 1'b1;
                        end
                    endcase
                end
                RD_B: begin
                    state_q <= WR;
                    tos_q   <= 1'b0;
                    pop_q   <= 1'b0;
                    push_q  <= 1'b1;
                    din_q   <= bin_res;
                end
                WR: begin
                    state_q <= IDLE;
                    push_q  <= 1'b0;
                    din_q   <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                RES: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    push_q  <= 1'b0;
                    pop_q   <= 1'b0;
                    tos_q   <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready  = ready_q;
    assign busy      = busy_q;
    assign stk_push  = push_q;
    assign stk_pop   = pop_q;
    assign stk_tos   = tos_q;
    assign stk_din   = din_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer: directed tests for stack_op_sequencer
// against a behavioural 32-entry LIFO model.
module tb_stack_op_sequencer;

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_DUP  = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic [2:0] op_code = OP_NOP;
    logic [7:0] op_imm = 8'h00;
    logic       op_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic       busy;
    logic       stk_push;
    logic       stk_pop;
    logic       stk_tos;
    logic [7:0] stk_din;
    wire  [7:0] stk_dout;
    logic       err;

    int total = 0;
    int bad = 0;
    int n_push = 0;
    int n_pop = 0;
    int n_tos = 0;
    int n_res = 0;

    logic [7:0] mem [32];
    logic [4:0] sp = 5'd0;

    always #5 clk = ~clk;

    stack_op_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_imm   (op_imm),
        .res_valid(res_valid),
        .res_data (res_data),
        .busy     (busy),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .stk_tos  (stk_tos),
        .stk_din  (stk_din),
        .stk_dout (stk_dout),
        .err      (err)
    );

    // LIFO model: no reset, pointer wraps mod 32.
    assign stk_dout = stk_tos ? mem[sp - 5'd1] : 8'hzz;

    always @(posedge clk) begin
        if (stk_push) begin
            mem[sp] <= stk_din;
            sp <= sp + 5'd1;
        end else if (stk_pop) begin
            sp <= sp - 5'd1;
        end
    end

    // Control-rule checker and activity counters.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (stk_push && stk_pop) begin
                bad++;
                $display("FAIL push_pop_excl t=%0t got push=1 pop=1 want not both", $time);
            end
            total++;
            if (stk_tos && (stk_push || op_ready)) begin
                bad++;
                $display("FAIL tos_only_rd t=%0t got tos=1 push=%0b ready=%0b want 0 0",
                         $time, stk_push, op_ready);
            end
            total++;
            if (busy === op_ready) begin
                bad++;
                $display("FAIL busy_vs_ready t=%0t got busy=%0b ready=%0b want opposite",
                         $time, busy, op_ready);
            end
            if (stk_push) n_push++;
            if (stk_pop) n_pop++;
            if (stk_tos) n_tos++;
            if (res_valid) n_res++;
        end
    end

    task automatic clear_counts();
        n_push = 0;
        n_pop = 0;
        n_tos = 0;
        n_res = 0;
    endtask

    // Issue one op; low = cycles op_ready stayed low after accept.
    task automatic do_op(input logic [2:0] c, input logic [7:0] imm,
                         output int low);
        int g;
        g = 0;
        while (!op_ready && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!op_ready) begin
            total++;
            bad++;
            $display("FAIL ready_wait got op_ready=0 want 1 within 20 cycles");
        end
        op_valid = 1'b1;
        op_code = c;
        op_imm = imm;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code = OP_NOP;
        low = 0;
        while (!op_ready && low < 20) begin
            @(posedge clk);
            #1;
            low++;
        end
        if (low >= 20) begin
            total++;
            bad++;
            $display("FAIL op_timeout op=%0d got busy>=20 cycles want return", c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({op_ready, busy, stk_push, stk_pop, stk_tos, res_valid, err} !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_ctl got rdy/busy/push/pop/tos/rv/err=%b want 1000000",
                     {op_ready, busy, stk_push, stk_pop, stk_tos, res_valid, err});
        end
        total++;
        if ({stk_din, res_data} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_data got din=%h res=%h want 00 00", stk_din, res_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (op_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release got op_ready=%b want 1", op_ready);
        end
    endtask

    task automatic test_add();
        int low;
        do_op(OP_PUSH, 8'h05, low);
        total++;
        if (low != 1) begin
            bad++;
            $display("FAIL push_latency got %0d want 1", low);
        end
        do_op(OP_PUSH, 8'h03, low);
        clear_counts();
        do_op(OP_ADD, 8'h00, low);
        total++;
        if (low != 3) begin
            bad++;
            $display("FAIL add_latency got %0d want 3", low);
        end
        total++;
        if (n_push != 1 || n_pop != 2 || n_tos != 2) begin
            bad++;
            $display("FAIL add_ctl got push=%0d pop=%0d tos=%0d want 1 2 2",
                     n_push, n_pop, n_tos);
        end
        clear_counts();
        do_op(OP_POP, 8'h00, low);
        total++;
        if (low != 2) begin
            bad++;
            $display("FAIL pop_latency got %0d want 2", low);
        end
        total++;
        if (res_data !== 8'h08 || n_res != 1) begin
            bad++;
            $display("FAIL add_result got %h pulses=%0d want 08 1", res_data, n_res);
        end
    endtask

    task automatic test_sub_not();
        int low;
        do_op(OP_PUSH, 8'h02, low);
        do_op(OP_PUSH, 8'h07, low);
        do_op(OP_SUB, 8'h00, low);
        do_op(OP_POP, 8'h00, low);
        total++;
        if (res_data !== 8'hFB) begin
            bad++;
            $display("FAIL sub_wrap got %h want fb", res_data);
        end
        do_op(OP_PUSH, 8'hF0, low);
        do_op(OP_NOT, 8'h00, low);
        total++;
        if (low != 2) begin
            bad++;
            $display("FAIL not_latency got %0d want 2", low);
        end
        do_op(OP_POP, 8'h00, low);
        total++;
        if (res_data !== 8'h0F) begin
            bad++;
            $display("FAIL not_result got %h want 0f", res_data);
        end
    endtask

    task automatic test_dup_and();
        int low;
        do_op(OP_PUSH, 8'h3C, low);
        clear_counts();
        do_op(OP_DUP, 8'h00, low);
        total++;
        if (n_push != 1 || n_pop != 0 || low != 2) begin
            bad++;
            $display("FAIL dup_ctl got push=%0d pop=%0d low=%0d want 1 0 2",
                     n_push, n_pop, low);
        end
        do_op(OP_AND, 8'h00, low);
        do_op(OP_POP, 8'h00, low);
        total++;
        if (res_data !== 8'h3C) begin
            bad++;
            $display("FAIL dup_and got %h want 3c", res_data);
        end
    endtask

    task automatic test_nop_back_to_back();
        int acc;
        acc = 0;
        clear_counts();
        op_valid = 1'b1;
        op_code = OP_NOP;
        for (int i = 0; i < 4; i++) begin
            if (op_ready === 1'b1) acc++;
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        total++;
        if (acc != 4 || op_ready !== 1'b1) begin
            bad++;
            $display("FAIL nop_b2b got accepts=%0d want 4", acc);
        end
        total++;
        if (n_push + n_pop + n_tos + n_res != 0) begin
            bad++;
            $display("FAIL nop_quiet got push=%0d pop=%0d tos=%0d res=%0d want 0",
                     n_push, n_pop, n_tos, n_res);
        end
    endtask

    task automatic test_depth();
        int low;
        clear_counts();
        do_op(OP_POP, 8'h00, low);
        total++;
`ifdef STACK_DEPTH_CHECK_EN
        if (n_pop != 0 || n_res != 0 || err !== 1'b1 || low != 0) begin
            bad++;
            $display("FAIL empty_pop got pop=%0d res=%0d err=%b low=%0d want 0 0 1 0",
                     n_pop, n_res, err, low);
        end
`else
        if (n_pop != 1 || n_res != 1 || err !== 1'b0) begin
            bad++;
            $display("FAIL empty_pop got pop=%0d res=%0d err=%b want 1 1 0",
                     n_pop, n_res, err);
        end
`endif
        for (int i = 0; i < 32; i++) begin
            do_op(OP_PUSH, 8'(i), low);
        end
        clear_counts();
        do_op(OP_PUSH, 8'hAA, low);
        total++;
`ifdef STACK_DEPTH_CHECK_EN
        if (n_push != 0 || err !== 1'b1) begin
            bad++;
            $display("FAIL full_push got push=%0d err=%b want 0 1", n_push, err);
        end
`else
        if (n_push != 1 || err !== 1'b0) begin
            bad++;
            $display("FAIL full_push got push=%0d err=%b want 1 0", n_push, err);
        end
`endif
        for (int i = 0; i < 32; i++) begin
            do_op(OP_POP, 8'h00, low);
        end
        total++;
`ifdef STACK_DEPTH_CHECK_EN
        if (res_data !== 8'h00) begin
            bad++;
            $display("FAIL drain_last got %h want 00", res_data);
        end
`else
        if (res_data !== 8'h01) begin
            bad++;
            $display("FAIL drain_last got %h want 01", res_data);
        end
`endif
    endtask

    task automatic test_reset_mid_op();
        int low;
        do_op(OP_PUSH, 8'h05, low);
        do_op(OP_PUSH, 8'h03, low);
        op_valid = 1'b1;
        op_code = OP_ADD;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code = OP_NOP;
        @(posedge clk);
        #1;
        total++;
        if (stk_tos !== 1'b1 || stk_pop !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rd_b_seen got tos=%b pop=%b busy=%b want 1 1 1",
                     stk_tos, stk_pop, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({op_ready, busy, stk_push, stk_pop, stk_tos, res_valid, err} !== 7'b1000000) begin
            bad++;
            $display("FAIL midop_ctl got rdy/busy/push/pop/tos/rv/err=%b want 1000000",
                     {op_ready, busy, stk_push, stk_pop, stk_tos, res_valid, err});
        end
        total++;
        if ({stk_din, res_data} !== 16'h0000) begin
            bad++;
            $display("FAIL midop_data got din=%h res=%h want 00 00", stk_din, res_data);
        end
        clear_counts();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (n_push != 0 || op_ready !== 1'b1) begin
            bad++;
            $display("FAIL midop_nopush got push=%0d ready=%b want 0 1", n_push, op_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_not();
        test_dup_and();
        test_nop_back_to_back();
        test_depth();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
